// File: rtl/hps_sched_pkg.sv
// Shared types and constants for the HPS FPGA_ENA command sequencer.
package hps_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_XFER,
        ST_WAIT,
        ST_DROP
    } sched_state_t;

    localparam int TGT_ID_W = 4;
    localparam int IDX_W    = 10;
    localparam logic [15:0] DROP_WORD = 16'hFFFF;

    // Word index stops at its maximum value instead of wrapping.
    function automatic logic [IDX_W-1:0] idx_sat_inc(input logic [IDX_W-1:0] idx);
        return (&idx) ? idx : idx + 1'b1;
    endfunction

endpackage

// File: rtl/hps_sched_timeout.sv
// Loadable down-counter bounding how long the sequencer may sit in WAIT.
module hps_sched_timeout (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        i_load,
    input  logic [15:0] i_load_val,
    input  logic        i_en,
    output logic        o_expire
);

    logic [15:0] r_cnt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Loaded with limit-1, so expiry lands on the last permitted enabled cycle.
    assign o_expire = i_en && !i_load && (r_cnt == '0);

endmodule

// File: rtl/hps_fpga_sched.sv
// Routes FPGA_ENA transactions from the HPS to one of NTGT targets and stalls on busy.
// Optional WAIT timeout is built when HPS_SCHED_TIMEOUT_EN is defined.
module hps_fpga_sched
    import hps_sched_pkg::*;
#(
    parameter int NTGT    = 4,
    parameter int TIMEOUT = 4095
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 fpga_ena,
    input  logic                 io_strobe,
    input  logic [15:0]          io_din,
    output logic [15:0]          fpga_dout,
    output logic                 fpga_wait,
    output logic [NTGT-1:0]      tgt_sel,
    output logic                 tgt_stb,
    output logic [15:0]          tgt_din,
    output logic [IDX_W-1:0]     tgt_idx,
    input  logic [NTGT-1:0]      tgt_busy,
    input  logic [16*NTGT-1:0]   tgt_dout,
    output logic                 err_timeout,
    output logic                 err_proto
);

    sched_state_t          r_state, w_state_next;
    logic [TGT_ID_W-1:0]   r_id, w_id_next;
    logic [NTGT-1:0]       r_sel, w_sel_next;
    logic                  r_stb, w_stb_next;
    logic [15:0]           r_din, w_din_next;
    logic [IDX_W-1:0]      r_idx, w_idx_next;
    logic [15:0]           r_dout, w_dout_next;
    logic                  r_wait, w_wait_next;
    logic                  r_err_to, w_err_to_next;
    logic                  r_err_proto, w_err_proto_next;
    logic                  w_expire;

    logic [TGT_ID_W-1:0]   w_cmd_id;
    logic                  w_id_ok;
    logic [15:0]           w_tgt_word [16];
    logic [15:0]           w_busy_ext;

    // Pad per-target inputs to the full 16-entry ID space so a 4-bit ID indexes cleanly.
    for (genvar gi = 0; gi < 16; gi++) begin : g_tgt
        if (gi < NTGT) begin : g_on
            assign w_tgt_word[gi] = tgt_dout[16*gi +: 16];
            assign w_busy_ext[gi] = tgt_busy[gi];
        end else begin : g_off
            assign w_tgt_word[gi] = '0;
            assign w_busy_ext[gi] = 1'b0;
        end
    end

    assign w_cmd_id = io_din[15:12];
    assign w_id_ok  = 32'(w_cmd_id) < NTGT;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_id        <= '0;
            r_sel       <= '0;
            r_stb       <= 1'b0;
            r_din       <= '0;
            r_idx       <= '0;
            r_dout      <= '0;
            r_wait      <= 1'b0;
            r_err_to    <= 1'b0;
            r_err_proto <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_id        <= w_id_next;
            r_sel       <= w_sel_next;
            r_stb       <= w_stb_next;
            r_din       <= w_din_next;
            r_idx       <= w_idx_next;
            r_dout      <= w_dout_next;
            r_wait      <= w_wait_next;
            r_err_to    <= w_err_to_next;
            r_err_proto <= w_err_proto_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_id_next        = r_id;
        w_sel_next       = r_sel;
        w_stb_next       = 1'b0;
        w_din_next       = r_din;
        w_idx_next       = r_idx;
        w_dout_next      = r_dout;
        w_wait_next      = r_wait;
        w_err_to_next    = r_err_to;
        w_err_proto_next = r_err_proto;

        if (!fpga_ena) begin
            w_state_next = ST_IDLE;
            w_sel_next   = '0;
            w_idx_next   = '0;
            w_wait_next  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: w_state_next = ST_CMD;
                ST_CMD: begin
                    if (io_strobe) begin
                        w_id_next        = w_cmd_id;
                        w_err_to_next    = 1'b0;
                        w_err_proto_next = 1'b0;
                        if (w_id_ok) begin
                            // The command word doubles as payload word 0.
                            w_sel_next   = NTGT'(1) << w_cmd_id;
                            w_stb_next   = 1'b1;
                            w_din_next   = io_din;
                            w_idx_next   = '0;
                            w_wait_next  = 1'b1;
                            w_state_next = ST_WAIT;
                        end else begin
                            w_sel_next   = '0;
                            w_dout_next  = DROP_WORD;
                            w_wait_next  = 1'b0;
                            w_state_next = ST_DROP;
                        end
                    end
                end
                ST_XFER: begin
                    if (io_strobe) begin
                        w_stb_next   = 1'b1;
                        w_din_next   = io_din;
                        w_wait_next  = 1'b1;
                        w_state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (io_strobe) begin
                        w_err_proto_next = 1'b1;
                    end else if (!w_busy_ext[r_id]) begin
                        w_dout_next  = w_tgt_word[r_id];
                        w_idx_next   = idx_sat_inc(r_idx);
                        w_wait_next  = 1'b0;
                        w_state_next = ST_XFER;
                    end else if (w_expire) begin
                        w_err_to_next = 1'b1;
                        w_sel_next    = '0;
                        w_dout_next   = DROP_WORD;
                        w_wait_next   = 1'b0;
                        w_state_next  = ST_DROP;
                    end
                end
                ST_DROP: w_state_next = ST_DROP;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

`ifdef HPS_SCHED_TIMEOUT_EN
    localparam logic [15:0] TO_LOAD = 16'(TIMEOUT - 1);
    logic w_to_load;
    assign w_to_load = (w_state_next == ST_WAIT) && (r_state != ST_WAIT);

    hps_sched_timeout u_timeout (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .i_load     (w_to_load),
        .i_load_val (TO_LOAD),
        .i_en       (r_state == ST_WAIT),
        .o_expire   (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    assign fpga_dout   = r_dout;
    assign fpga_wait   = r_wait;
    assign tgt_sel     = r_sel;
    assign tgt_stb     = r_stb;
    assign tgt_din     = r_din;
    assign tgt_idx     = r_idx;
    assign err_timeout = r_err_to;
    assign err_proto   = r_err_proto;

endmodule

// File: tb/tb_hps_fpga_sched.sv
// Directed-random bench for hps_fpga_sched with a transaction-level expectation model.
module tb_hps_fpga_sched;

    localparam int NTGT    = 4;
    localparam int TIMEOUT = 8;

    logic                clk_sys   = 1'b0;
    logic                reset_n   = 1'b0;
    logic                fpga_ena  = 1'b0;
    logic                io_strobe = 1'b0;
    logic [15:0]         io_din    = '0;
    logic [15:0]         fpga_dout;
    logic                fpga_wait;
    logic [NTGT-1:0]     tgt_sel;
    logic                tgt_stb;
    logic [15:0]         tgt_din;
    logic [9:0]          tgt_idx;
    logic [NTGT-1:0]     tgt_busy  = '0;
    logic [16*NTGT-1:0]  tgt_dout  = '0;
    logic                err_timeout;
    logic                err_proto;

    int n_checks  = 0;
    int n_pass    = 0;
    int stb_count = 0;

    hps_fpga_sched #(.NTGT(NTGT), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .fpga_ena    (fpga_ena),
        .io_strobe   (io_strobe),
        .io_din      (io_din),
        .fpga_dout   (fpga_dout),
        .fpga_wait   (fpga_wait),
        .tgt_sel     (tgt_sel),
        .tgt_stb     (tgt_stb),
        .tgt_din     (tgt_din),
        .tgt_idx     (tgt_idx),
        .tgt_busy    (tgt_busy),
        .tgt_dout    (tgt_dout),
        .err_timeout (err_timeout),
        .err_proto   (err_proto)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) if (reset_n && tgt_stb) stb_count++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sel"},  32'(tgt_sel), 0);
        check({tag, "_stb"},  32'(tgt_stb), 0);
        check({tag, "_din"},  32'(tgt_din), 0);
        check({tag, "_idx"},  32'(tgt_idx), 0);
        check({tag, "_dout"}, 32'(fpga_dout), 0);
        check({tag, "_wait"}, 32'(fpga_wait), 0);
        check({tag, "_eto"},  32'(err_timeout), 0);
        check({tag, "_epr"},  32'(err_proto), 0);
    endtask

    // Leave the current frame, confirm IDLE outputs, then reopen so the next cycle is CMD.
    task automatic start_txn();
        fpga_ena = 1'b0;
        tick();
        check("idle_sel",  32'(tgt_sel), 0);
        check("idle_wait", 32'(fpga_wait), 0);
        check("idle_idx",  32'(tgt_idx), 0);
        fpga_ena = 1'b1;
        tick();
    endtask

    // One forwarded word: target busy for busy_n cycles after its strobe, expected
    // WAIT length busy_n+1, reply captured on exit, index advanced with saturation.
    task automatic send_word(input logic [15:0] w, input int busy_n, input int tgt,
                             input int exp_idx, input logic [15:0] reply);
        int waits;
        int stb_before;
        int idx_after;
        logic [NTGT-1:0] sel_exp;
        tgt_dout = {$urandom, $urandom};
        tgt_dout[16*tgt +: 16] = reply;
        sel_exp    = NTGT'(1) << tgt;
        idx_after  = (exp_idx >= 1023) ? 1023 : exp_idx + 1;
        stb_before = stb_count;
        io_din = w;
        io_strobe = 1'b1;
        tick();
        io_strobe = 1'b0;
        io_din = 16'($urandom);
        check("fwd_stb",  32'(tgt_stb), 1);
        check("fwd_din",  32'(tgt_din), 32'(w));
        check("fwd_idx",  32'(tgt_idx), 32'(exp_idx));
        check("fwd_sel",  32'(tgt_sel), 32'(sel_exp));
        check("wait_rise", 32'(fpga_wait), 1);
        tgt_busy = '0;
        tgt_busy[tgt] = (busy_n > 0);
        waits = 1;
        for (int k = 1; k <= busy_n + 20; k++) begin
            tick();
            tgt_busy[tgt] = (k < busy_n);
            if (!fpga_wait) break;
            waits++;
        end
        check("wait_len", 32'(waits), 32'(busy_n + 1));
        check("stb_once", 32'(stb_count - stb_before), 1);
        check("reply",    32'(fpga_dout), 32'(reply));
        check("idx_next", 32'(tgt_idx), 32'(idx_after));
        tgt_busy = '0;
    endtask

    initial begin
        int waits;
        int tgt;
        int stb_before;
        logic [15:0] reply;

        // Reset state, during and just after reset.
        tick();
        tick();
        check_all_zero("rst_hold");
        reset_n = 1'b1;
        tick();
        check_all_zero("rst_rel");

        // Two-word write to target 1, then random payload with random busy lengths.
        fpga_ena = 1'b1;
        tick();
        send_word(16'h1005, 2, 1, 0, 16'h1234);
        send_word(16'hABCD, 2, 1, 1, 16'h1234);
        for (int k = 2; k < 8; k++)
            send_word(16'($urandom), $urandom_range(0, 4), 1, k, 16'($urandom));

        // Absent target: transaction swallowed.
        start_txn();
        stb_before = stb_count;
        io_din = {4'($urandom_range(4, 15)), 12'($urandom)};
        io_strobe = 1'b1;
        tick();
        check("drop_stb",  32'(tgt_stb), 0);
        check("drop_wait", 32'(fpga_wait), 0);
        check("drop_dout", 32'(fpga_dout), 32'h0000FFFF);
        check("drop_sel",  32'(tgt_sel), 0);
        for (int k = 0; k < 3; k++) begin
            io_din = 16'($urandom);
            tick();
        end
        io_strobe = 1'b0;
        tick();
        check("drop_nostb", 32'(stb_count - stb_before), 0);
        check("drop_wait2", 32'(fpga_wait), 0);
        check("drop_dout2", 32'(fpga_dout), 32'h0000FFFF);

        // Target held busy indefinitely.
        start_txn();
        tgt = $urandom_range(0, NTGT - 1);
        io_din = {4'(tgt), 12'($urandom)};
        io_strobe = 1'b1;
        tick();
        io_strobe = 1'b0;
        tgt_busy[tgt] = 1'b1;
        waits = 1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (!fpga_wait) break;
            waits++;
        end
`ifdef HPS_SCHED_TIMEOUT_EN
        check("to_len",  32'(waits), 32'(TIMEOUT));
        check("to_flag", 32'(err_timeout), 1);
        check("to_dout", 32'(fpga_dout), 32'h0000FFFF);
        check("to_sel",  32'(tgt_sel), 0);
        stb_before = stb_count;
        io_din = 16'($urandom);
        io_strobe = 1'b1;
        tick();
        io_strobe = 1'b0;
        tick();
        check("to_nostb", 32'(stb_count - stb_before), 0);
        check("to_wait0", 32'(fpga_wait), 0);
`else
        check("noto_len",  32'(waits), 41);
        check("noto_flag", 32'(err_timeout), 0);
        fpga_ena = 1'b0;
        tick();
        check("noto_wait0", 32'(fpga_wait), 0);
        check("noto_sel0",  32'(tgt_sel), 0);
`endif
        tgt_busy = '0;

        // Strobe during WAIT: dropped and flagged; flags clear on the next command.
        start_txn();
        reply = 16'($urandom);
        tgt_dout[16*2 +: 16] = reply;
        stb_before = stb_count;
        io_din = {4'd2, 12'($urandom)};
        io_strobe = 1'b1;
        tick();
        io_strobe = 1'b0;
        tgt_busy[2] = 1'b1;
        check("cmd_clr_eto", 32'(err_timeout), 0);
        check("cmd_clr_epr", 32'(err_proto), 0);
        tick();
        io_din = 16'($urandom);
        io_strobe = 1'b1;
        tick();
        io_strobe = 1'b0;
        check("proto_flag", 32'(err_proto), 1);
        check("proto_wait", 32'(fpga_wait), 1);
        tgt_busy[2] = 1'b0;
        tick();
        tick();
        check("proto_stb",  32'(stb_count - stb_before), 1);
        check("proto_wait0", 32'(fpga_wait), 0);
        check("proto_dout", 32'(fpga_dout), 32'(reply));
        start_txn();
        check("proto_sticky", 32'(err_proto), 1);
        send_word({4'd0, 12'($urandom)}, 0, 0, 0, 16'($urandom));
        check("proto_clr", 32'(err_proto), 0);

        // Frame dropped in the middle of WAIT.
        start_txn();
        io_din = {4'd3, 12'($urandom)};
        io_strobe = 1'b1;
        tick();
        io_strobe = 1'b0;
        tgt_busy[3] = 1'b1;
        tick();
        tick();
        fpga_ena = 1'b0;
        tick();
        check("abort_sel",  32'(tgt_sel), 0);
        check("abort_wait", 32'(fpga_wait), 0);
        check("abort_idx",  32'(tgt_idx), 0);
        tgt_busy = '0;

        // Asynchronous reset in the middle of XFER.
        fpga_ena = 1'b1;
        tick();
        send_word({4'd1, 12'($urandom)}, 1, 1, 0, 16'($urandom) | 16'h0001);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        fpga_ena = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check_all_zero("post_rst");

        // Long transaction: index saturates while forwarding continues.
        fpga_ena = 1'b1;
        tick();
        for (int k = 0; k < 1030; k++)
            send_word((k == 0) ? {4'd1, 12'($urandom)} : 16'($urandom),
                      $urandom_range(0, 1), 1, (k > 1023) ? 1023 : k, 16'($urandom));
        check("sat_idx", 32'(tgt_idx), 1023);
        fpga_ena = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
